// File: rtl/mipi_csi2_depacketizer.sv
// CSI-2 single-lane receive parser: turns the HS byte stream into vsync/href/pixel video.
// The parser state is mirrored on fsm_state for debug visibility.
module mipi_csi2_depacketizer #(
   parameter int DATA_WIDTH = 10
) (
   input  logic                  pixclk,
   input  logic                  resetb,
   input  logic                  enable,
   input  logic                  sot,
   input  logic                  eot,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  vsync,
   output logic                  href,
   output logic                  pix_valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic [15:0]           frame_num,
   output logic [15:0]           line_cnt,
   output logic                  err_short,
   output logic                  err_dt,
   output logic [2:0]            fsm_state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CRC     = 3'd3,
      ST_SKIP    = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  hdr_cnt;
   logic [5:0]  dt;
   logic [15:0] wc;
   logic [15:0] byte_rem;
   logic        raw10;
   logic [2:0]  grp_idx;
   logic [7:0]  msb [0:3];
   logic [9:0]  sh_pix [0:2];
   logic [1:0]  sh_cnt;
   logic        crc_cnt;

   logic start, take, hdr_done, is_long, emit, short_nxt, dt_nxt;

   assign fsm_state = state;

   always_comb begin
      state_nxt = state;
      short_nxt = 1'b0;
      dt_nxt    = 1'b0;
      start     = enable && sot && byte_valid;
      take      = enable && byte_valid && !start;
      hdr_done  = take && (state == ST_HDR) && (hdr_cnt == 2'd3);
      is_long   = (dt == 6'h2A) || (dt == 6'h2B);
      emit      = enable && ((sh_cnt != 2'd0) ||
                  (take && (state == ST_PAYLOAD) && (!raw10 || (grp_idx == 3'd4))));
      if (!enable) begin
         state_nxt = ST_IDLE;
      end else if (start) begin
         state_nxt = ST_HDR;
         short_nxt = (state == ST_PAYLOAD) || (state == ST_CRC);
      end else begin
         case (state)
            ST_HDR: begin
               if (hdr_done) begin
                  if (dt <= 6'h03) begin
                     state_nxt = ST_IDLE;
                  end else if (is_long) begin
                     state_nxt = (wc != 16'd0) ? ST_PAYLOAD : ST_CRC;
                  end else begin
                     state_nxt = ST_SKIP;
                     dt_nxt    = 1'b1;
                  end
               end
            end
            ST_PAYLOAD: if (take && (byte_rem == 16'd1)) state_nxt = ST_CRC;
            ST_CRC:     if (take && crc_cnt) state_nxt = ST_IDLE;
            default: ;
         endcase
         // eot is only short if the byte it rides with (if any) did not finish the packet
         if (eot && (state != ST_IDLE)) begin
            short_nxt = (state_nxt == ST_HDR) || (state_nxt == ST_PAYLOAD) ||
                        (state_nxt == ST_CRC);
            state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge pixclk or negedge resetb) begin
      if (!resetb) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge pixclk or negedge resetb) begin
      if (!resetb) begin
         vsync     <= 1'b0;
         href      <= 1'b0;
         pix_valid <= 1'b0;
         data      <= '0;
         frame_num <= 16'd0;
         line_cnt  <= 16'd0;
         err_short <= 1'b0;
         err_dt    <= 1'b0;
         hdr_cnt   <= 2'd0;
         dt        <= 6'd0;
         wc        <= 16'd0;
         byte_rem  <= 16'd0;
         raw10     <= 1'b0;
         grp_idx   <= 3'd0;
         sh_cnt    <= 2'd0;
         crc_cnt   <= 1'b0;
         for (int i = 0; i < 4; i++) msb[i] <= 8'd0;
         for (int i = 0; i < 3; i++) sh_pix[i] <= 10'd0;
      end else begin
         err_short <= short_nxt;
         err_dt    <= dt_nxt;
         pix_valid <= 1'b0;
         if (!enable) begin
            sh_cnt <= 2'd0;
            href   <= 1'b0;
         end else begin
            if (sh_cnt != 2'd0) begin
               data      <= DATA_WIDTH'(sh_pix[0]);
               pix_valid <= 1'b1;
               sh_pix[0] <= sh_pix[1];
               sh_pix[1] <= sh_pix[2];
               sh_cnt    <= sh_cnt - 2'd1;
            end
            // A line ends once the payload is over and the shifter has fully drained
            if (emit) begin
               href <= 1'b1;
            end else if (href && (state != ST_PAYLOAD) && (sh_cnt == 2'd0)) begin
               href     <= 1'b0;
               line_cnt <= line_cnt + 16'd1;
            end
            if (start) begin
               dt      <= byte_data[5:0];
               hdr_cnt <= 2'd1;
            end else if (take) begin
               case (state)
                  ST_HDR: begin
                     hdr_cnt <= hdr_cnt + 2'd1;
                     if (hdr_cnt == 2'd1) wc[7:0]  <= byte_data;
                     if (hdr_cnt == 2'd2) wc[15:8] <= byte_data;
                     if (hdr_done) begin
                        if (dt == 6'h00) begin
                           vsync     <= 1'b1;
                           frame_num <= wc;
                           line_cnt  <= 16'd0;
                        end
                        if (dt == 6'h01) vsync <= 1'b0;
                        byte_rem <= wc;
                        raw10    <= dt[0];
                        grp_idx  <= 3'd0;
                        crc_cnt  <= 1'b0;
                     end
                  end
                  ST_PAYLOAD: begin
                     byte_rem <= byte_rem - 16'd1;
                     if (!raw10) begin
                        data      <= DATA_WIDTH'(byte_data);
                        pix_valid <= 1'b1;
                     end else if (grp_idx != 3'd4) begin
                        msb[grp_idx[1:0]] <= byte_data;
                        grp_idx           <= grp_idx + 3'd1;
                     end else begin
                        // LSB byte: pixel 0 goes out now, pixels 1..3 queue in the shifter
                        data      <= DATA_WIDTH'({msb[0], byte_data[1:0]});
                        pix_valid <= 1'b1;
                        sh_pix[0] <= {msb[1], byte_data[3:2]};
                        sh_pix[1] <= {msb[2], byte_data[5:4]};
                        sh_pix[2] <= {msb[3], byte_data[7:6]};
                        sh_cnt    <= 2'd3;
                        grp_idx   <= 3'd0;
                     end
                  end
                  ST_CRC: crc_cnt <= 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
